// File: rtl/ex_mem_stage_buf.sv
// EX/MEM pipeline stage: valid/ready handshake, 2-entry skid buffer, flush, zeroed bubbles.
// Define EXMEM_PERF_EN to add saturating stall_cnt / bubble_cnt counters.
module ex_mem_stage_buf #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CTRL_W  = 8,
   parameter int unsigned OPC_W   = 6
`ifdef EXMEM_PERF_EN
   , parameter int unsigned CNT_W = 16
`endif
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [OPC_W-1:0]          opcode_ex,
   input  logic signed [DATA_W-1:0]  ex_data_1,
   input  logic signed [DATA_W-1:0]  ex_data_2,
   input  logic [RADDR_W-1:0]        rd_ex,
   input  logic [CTRL_W-1:0]         control_ALU,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [DATA_W-1:0]  data_in,
   output logic signed [DATA_W-1:0]  mem_addr,
   output logic signed [DATA_W-1:0]  save_mem,
   output logic [RADDR_W-1:0]        rd_mem,
   output logic [CTRL_W-1:0]         control_MEM,
   output logic [OPC_W-1:0]          opcode_wb
`ifdef EXMEM_PERF_EN
   , output logic [CNT_W-1:0]        stall_cnt
   , output logic [CNT_W-1:0]        bubble_cnt
`endif
);

   typedef struct packed {
      logic [OPC_W-1:0]   opc;
      logic [DATA_W-1:0]  d1;
      logic [DATA_W-1:0]  d2;
      logic [RADDR_W-1:0] rd;
      logic [CTRL_W-1:0]  ctrl;
   } ent_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   ent_t   r_main;
   ent_t   r_skid;
   ent_t   w_main_nxt;
   ent_t   w_skid_nxt;
   ent_t   w_in_ent;
   logic   r_out_valid;
   logic   r_in_ready;
   logic   w_accept;
   logic   w_consume;

   assign w_in_ent  = {opcode_ex, ex_data_1, ex_data_2, rd_ex, control_ALU};
   assign w_accept  = in_valid & r_in_ready;
   assign w_consume = r_out_valid & out_ready;

   // State register: state counts held entries.
   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic; flush squashes everything held.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
            ST_ONE: begin
               if (w_accept && !w_consume)      w_state_nxt = ST_TWO;
               else if (!w_accept && w_consume) w_state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (w_consume) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Entry movement; an emptied main entry is zeroed so bubbles read as no-ops.
   always_comb begin
      w_main_nxt = r_main;
      w_skid_nxt = r_skid;
      if (flush) begin
         w_main_nxt = '0;
         w_skid_nxt = '0;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_accept) w_main_nxt = w_in_ent;
            ST_ONE: begin
               if (w_accept && w_consume)       w_main_nxt = w_in_ent;
               else if (w_accept)               w_skid_nxt = w_in_ent;
               else if (w_consume)              w_main_nxt = '0;
            end
            ST_TWO: begin
               if (w_consume) begin
                  w_main_nxt = r_skid;
                  w_skid_nxt = '0;
               end
            end
            default: begin
               w_main_nxt = '0;
               w_skid_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_main      <= '0;
         r_skid      <= '0;
      end else begin
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         r_in_ready  <= (w_state_nxt != ST_TWO);
         r_main      <= w_main_nxt;
         r_skid      <= w_skid_nxt;
      end
   end

   assign out_valid   = r_out_valid;
   assign in_ready    = r_in_ready;
   assign opcode_wb   = r_main.opc;
   assign data_in     = r_main.d1;
   assign mem_addr    = r_main.d2;
   assign save_mem    = r_main.d2;
   assign rd_mem      = r_main.rd;
   assign control_MEM = r_main.ctrl;

`ifdef EXMEM_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   // Saturating counters; only reset clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (r_out_valid && !out_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (!r_out_valid && (r_bubble_cnt != '1))
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Self-checking bench for ex_mem_stage_buf: directed scenarios plus random traffic,
// scored against a queue model of the held entries.
module tb_ex_mem_stage_buf;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;
   localparam int unsigned CW = 8;
   localparam int unsigned OW = 6;
`ifdef EXMEM_PERF_EN
   localparam int unsigned NW = 4;
`endif

   typedef struct packed {
      logic [OW-1:0] opc;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
      logic [RW-1:0] rd;
      logic [CW-1:0] ctrl;
   } ent_t;

   logic          clock;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [OW-1:0] opcode_ex;
   logic [DW-1:0] ex_data_1;
   logic [DW-1:0] ex_data_2;
   logic [RW-1:0] rd_ex;
   logic [CW-1:0] control_ALU;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] data_in;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] save_mem;
   logic [RW-1:0] rd_mem;
   logic [CW-1:0] control_MEM;
   logic [OW-1:0] opcode_wb;
`ifdef EXMEM_PERF_EN
   logic [NW-1:0] stall_cnt;
   logic [NW-1:0] bubble_cnt;
`endif

   ex_mem_stage_buf #(
      .DATA_W(DW), .RADDR_W(RW), .CTRL_W(CW), .OPC_W(OW)
`ifdef EXMEM_PERF_EN
      , .CNT_W(NW)
`endif
   ) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode_ex(opcode_ex), .ex_data_1(ex_data_1), .ex_data_2(ex_data_2),
      .rd_ex(rd_ex), .control_ALU(control_ALU),
      .out_valid(out_valid), .out_ready(out_ready),
      .data_in(data_in), .mem_addr(mem_addr), .save_mem(save_mem),
      .rd_mem(rd_mem), .control_MEM(control_MEM), .opcode_wb(opcode_wb)
`ifdef EXMEM_PERF_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: entries accepted by the stage and not yet consumed, oldest first.
   ent_t q[$];
   ent_t exp_e;
   ent_t in_e;
   bit   armed = 1'b0;
   bit   m_rdy;
   int   m_stall = 0;
   int   m_bub   = 0;

   // Monitor: samples on the falling edge, checks, then advances the model past the next rising edge.
   always @(negedge clock) begin
      if (reset) begin
         q.delete();
         armed   = 1'b1;
         m_stall = 0;
         m_bub   = 0;
      end else if (armed) begin
         m_rdy = (q.size() < 2);
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready",  64'(in_ready),  64'(m_rdy));
         exp_e = (q.size() != 0) ? q[0] : '0;
         chk("opcode_wb",   64'(opcode_wb),   64'(exp_e.opc));
         chk("data_in",     64'(data_in),     64'(exp_e.d1));
         chk("mem_addr",    64'(mem_addr),    64'(exp_e.d2));
         chk("save_mem",    64'(save_mem),    64'(exp_e.d2));
         chk("rd_mem",      64'(rd_mem),      64'(exp_e.rd));
         chk("control_MEM", 64'(control_MEM), 64'(exp_e.ctrl));
`ifdef EXMEM_PERF_EN
         chk("stall_cnt",  64'(stall_cnt),  64'(m_stall));
         chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
         if (q.size() != 0 && !out_ready && m_stall < (1 << NW) - 1) m_stall++;
         if (q.size() == 0 && m_bub < (1 << NW) - 1) m_bub++;
`endif
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if (flush) begin
            q.delete();
         end else if (in_valid && m_rdy) begin
            in_e.opc  = opcode_ex;
            in_e.d1   = ex_data_1;
            in_e.d2   = ex_data_2;
            in_e.rd   = rd_ex;
            in_e.ctrl = control_ALU;
            q.push_back(in_e);
         end
      end
   end

   // Drive one cycle of inputs, then advance to just after the next rising edge.
   task automatic drv(input logic v, input logic rdy, input logic fl, input logic [OW-1:0] o,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [RW-1:0] r, input logic [CW-1:0] c);
      in_valid    = v;
      out_ready   = rdy;
      flush       = fl;
      opcode_ex   = o;
      ex_data_1   = a;
      ex_data_2   = b;
      rd_ex       = r;
      control_ALU = c;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic rdy);
      drv(1'b0, rdy, 1'b0, '0, '0, '0, '0, '0);
   endtask

   initial begin
      reset = 1'b1;
      drv(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
      idle(1'b0);
      reset = 1'b0;
      idle(1'b1);

      // Back-to-back stream
      for (int i = 0; i < 4; i++)
         drv(1'b1, 1'b1, 1'b0, OW'(i + 1), DW'(10 + i), DW'(32'h100 + i), RW'(1 + i), CW'(8'h11 * i));
      idle(1'b1);
      idle(1'b1);

      // Stall fills skid, then drain in order
      drv(1'b1, 1'b0, 1'b0, 6'h01, 32'hA, 32'h200, 5'd7, 8'h01);
      drv(1'b1, 1'b0, 1'b0, 6'h02, 32'hB, 32'h204, 5'd8, 8'h02);
      idle(1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Flush while full, with a simultaneous input that must be dropped
      drv(1'b1, 1'b0, 1'b0, 6'h03, 32'h1, 32'h300, 5'd3, 8'h03);
      drv(1'b1, 1'b0, 1'b0, 6'h04, 32'h2, 32'h304, 5'd4, 8'h04);
      drv(1'b1, 1'b0, 1'b1, 6'h05, 32'h3, 32'h308, 5'd9, 8'h05);
      idle(1'b1);
      idle(1'b1);

      // Reset while full and stalled, then one lone entry
      drv(1'b1, 1'b0, 1'b0, 6'h06, 32'h4, 32'h400, 5'd10, 8'h06);
      drv(1'b1, 1'b0, 1'b0, 6'h07, 32'h5, 32'h404, 5'd11, 8'h07);
      reset = 1'b1;
      drv(1'b1, 1'b0, 1'b1, 6'h08, 32'h6, 32'h408, 5'd13, 8'h08);
      reset = 1'b0;
      drv(1'b1, 1'b1, 1'b0, 6'h09, 32'h7, 32'h40C, 5'd12, 8'h09);
      idle(1'b1);
      idle(1'b1);

      // Opcode/control pairing across a stall
      drv(1'b1, 1'b0, 1'b0, 6'h23, 32'hFFFF_FFF0, 32'h8000_0000, 5'd5, 8'hA5);
      idle(1'b0);
      idle(1'b0);
      drv(1'b1, 1'b0, 1'b0, 6'h2B, 32'h7FFF_FFFF, 32'h0000_0010, 5'd6, 8'h5A);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

`ifdef EXMEM_PERF_EN
      reset = 1'b1;
      idle(1'b0);
      reset = 1'b0;
      drv(1'b1, 1'b0, 1'b0, 6'h11, 32'h1, 32'h2, 5'd1, 8'h01);
      repeat (20) idle(1'b0);
      chk("stall_sat", 64'(stall_cnt), 64'd15);
      drv(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0);
      chk("stall_after_flush", 64'(stall_cnt), 64'd15);
      reset = 1'b1;
      idle(1'b0);
      reset = 1'b0;
      chk("stall_after_reset", 64'(stall_cnt), 64'd0);
      idle(1'b1);
`endif

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 127) == 0);
         drv(1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 9) < 6)),
             1'(($urandom_range(0, 31) == 0)), OW'($urandom), DW'($urandom),
             DW'($urandom), RW'($urandom), CW'($urandom));
      end
      reset = 1'b0;
      repeat (4) idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage_buf.md
Name: ex_mem_stage_buf

Overview:
- Parametrised EX/MEM pipeline stage; successor to the fixed-width EX/MEM write register.
- Adds valid/ready handshake, a 2-entry skid buffer (main + skid), pipeline flush, and zeroed bubbles.
- Sits between the ALU/EX stage and the data-memory stage, so a MEM-side stall back-pressures EX without losing an instruction.

Parameters:
- DATA_W, 32, width of ALU result, memory address and store data.
- RADDR_W, 5, destination register index width.
- CTRL_W, 8, control bundle width passed from the ALU to MEM.
- OPC_W, 6, opcode width forwarded to WB.
- CNT_W, 16, performance counter width (used only with EXMEM_PERF_EN).

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries (branch/exception squash)
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept; registered
- opcode_ex  in  OPC_W  opcode of EX instruction
- ex_data_1  in  DATA_W  signed ALU result / write-back data
- ex_data_2  in  DATA_W  signed address / store operand
- rd_ex  in  RADDR_W  destination register
- control_ALU  in  CTRL_W  control bundle from EX
- out_valid  out  1  data_in..opcode_wb hold a valid instruction
- out_ready  in  1  MEM stage consumes the entry this cycle
- data_in  out  DATA_W  signed, registered ex_data_1
- mem_addr  out  DATA_W  signed, registered ex_data_2
- save_mem  out  DATA_W  signed, registered ex_data_2 (store data)
- rd_mem  out  RADDR_W  registered rd_ex
- control_MEM  out  CTRL_W  registered control_ALU
- opcode_wb  out  OPC_W  registered opcode_ex, from the same entry as the other payload outputs
- stall_cnt  out  CNT_W  present only with EXMEM_PERF_EN
- bubble_cnt  out  CNT_W  present only with EXMEM_PERF_EN

Behaviour:
- Clock and reset: single clock `clock`; `reset` is synchronous and active-high. While reset is sampled high: out_valid=0, in_ready=1, all payload outputs=0, skid empty, state EMPTY.
- Entries and output: outputs are driven from the main entry; the skid entry holds one overflow instruction.
- Definitions: accept = in_valid & in_ready; consume = out_valid & out_ready.
- State machine (state = number of held entries):
  - EMPTY: accept -> main<=input, ONE. Otherwise stay EMPTY.
  - ONE: accept & consume -> main<=input, stay ONE. accept & !consume -> skid<=input, TWO. !accept & consume -> EMPTY. Otherwise hold.
  - TWO: in_ready=0. consume -> main<=skid, ONE. Otherwise hold.
- in_ready: registered; the next value is 0 only when the next state is TWO.
- Latency: 1 cycle from accept to out_valid when the stage is empty or being drained. Full throughput of 1 instruction/cycle while out_ready=1.
- Bubbles: whenever out_valid=0, all payload outputs read 0, so control_MEM=0 is a safe no-op.
- Payload integrity: opcode_wb always travels with its own entry.
- Flush: synchronous.
  - Next cycle: state EMPTY, out_valid=0, payload=0, in_ready=1.
  - Flush overrides a simultaneous accept; that input is dropped.
  - in_valid during flush is ignored.
- Reset vs flush: reset takes priority over flush and over all other inputs. Reset mid-stall discards both entries.
- Stalled hold: holding out_valid=1 with out_ready=0 keeps payload stable cycle to cycle.
- Data handling: no arithmetic. Signed fields are copied bit-exact; no width conversion occurs inside the block.

Optional Feature:
- Macro: EXMEM_PERF_EN.
- Defined:
  - stall_cnt increments on each cycle with out_valid & !out_ready.
  - bubble_cnt increments on each cycle with !out_valid.
  - Both saturate at 2^CNT_W-1.
  - Both clear on reset only; flush does not clear them.
- Undefined: stall_cnt and bubble_cnt ports and their logic are absent.

Test Plan:
- Reset, then stream 4 entries (ex_data_1=10..13, ex_data_2=0x100..0x103, rd_ex=1..4) with out_ready=1 -> outputs appear 1 cycle after each accept, back-to-back. mem_addr=save_mem=0x100..0x103. in_ready stays 1.
- Load entry A (rd=7). Hold out_ready=0 and present B (rd=8) -> B is accepted into skid and in_ready drops to 0; outputs hold A. Release out_ready -> A, then B, on consecutive cycles; in_ready returns to 1.
- TWO state, assert flush with in_valid=1 -> next cycle out_valid=0, all payload=0, in_ready=1. The flushed-cycle input never appears at the outputs.
- Assert reset while in TWO with out_ready=0 -> next cycle out_valid=0, payload=0, in_ready=1. A subsequent single entry emerges alone.
- opcode_ex=0x23 with control_ALU=0xA5, then opcode_ex=0x2B with control_ALU=0x5A, with a stall between them -> opcode_wb and control_MEM pair 0x23/0xA5 and 0x2B/0x5A exactly.
- With EXMEM_PERF_EN and CNT_W=4: 20 stall cycles -> stall_cnt saturates at 15. A flush leaves stall_cnt unchanged; reset returns it to 0.
